// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Function : Shares a single-port data memory between the CPU MEM stage and a
//            DMA/loader port; CPU-priority with a DMA starvation limit.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_SIZE     = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // CPU (MEM stage) port
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_err,
    output logic                  err_flag,

    // DMA / loader port
    input  logic                  dma_valid,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ready,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,

    // Memory side
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    // Four bits cover the full legal STARVE_LIMIT range of 1..15.
    localparam int                     c_cnt_width    = 4;
    localparam logic [c_cnt_width-1:0] c_starve_limit = c_cnt_width'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0]  c_mem_size     = ADDR_WIDTH'(MEM_SIZE);

    logic [c_cnt_width-1:0] r_wait_cnt;
    logic                   r_err_flag;
    logic [DATA_WIDTH-1:0]  r_dma_rdata;
    logic                   r_dma_rvalid;

    logic [ADDR_WIDTH-1:0]  w_cpu_word;
    logic                   w_cpu_misaligned;
    logic                   w_cpu_out_of_range;
    logic                   w_cpu_err;
    logic                   w_dma_in_range;
    logic                   w_force_dma;
    logic                   w_gnt_dma;
    logic                   w_gnt_cpu;

    // ------------------------------------------------------------------
    // CPU address decode
    // ------------------------------------------------------------------
    assign w_cpu_word         = cpu_addr >> 2;
    assign w_cpu_misaligned   = (cpu_addr[1:0] != 2'b00);
    assign w_cpu_out_of_range = (w_cpu_word >= c_mem_size);
    assign w_cpu_err          = cpu_req & (w_cpu_misaligned | w_cpu_out_of_range);
    assign w_dma_in_range     = (dma_addr < c_mem_size);

    // ------------------------------------------------------------------
    // Grant: CPU first, unless DMA has waited STARVE_LIMIT cycles.
    // Both grants are held off while in reset so nothing reaches memory.
    // ------------------------------------------------------------------
    assign w_force_dma = dma_valid & (r_wait_cnt == c_starve_limit);
    assign w_gnt_dma   = rst_n & dma_valid & (~cpu_req | w_force_dma);
    assign w_gnt_cpu   = rst_n & cpu_req & ~w_gnt_dma;

    assign dma_ready   = w_gnt_dma;
    assign cpu_stall   = rst_n & cpu_req & ~w_gnt_cpu;
    assign cpu_err     = w_cpu_err;
    assign cpu_rdata   = (w_gnt_cpu & ~w_cpu_err) ? mem_rd_data : '0;

    // ------------------------------------------------------------------
    // Memory request mux
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        if (w_gnt_cpu) begin
            mem_addr    = w_cpu_word;
            mem_wr_data = cpu_wdata;
            mem_wr_en   = cpu_we & ~w_cpu_err;
        end else if (w_gnt_dma) begin
            mem_addr    = dma_addr;
            mem_wr_data = dma_wdata;
            mem_wr_en   = dma_we & w_dma_in_range;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter, sticky error flag and DMA read return
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt   <= '0;
            r_err_flag   <= 1'b0;
            r_dma_rdata  <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            if (w_gnt_dma || !dma_valid) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_starve_limit) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_gnt_cpu && w_cpu_err) begin
                r_err_flag <= 1'b1;
            end

            // Out-of-range DMA reads complete normally but return zero.
            if (w_gnt_dma && !dma_we) begin
                r_dma_rdata  <= w_dma_in_range ? mem_rd_data : '0;
                r_dma_rvalid <= 1'b1;
            end else begin
                r_dma_rvalid <= 1'b0;
            end
        end
    end

    assign err_flag   = r_err_flag;
    assign dma_rdata  = r_dma_rdata;
    assign dma_rvalid = r_dma_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Function : Directed self-checking bench for dmem_arbiter with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MEM_SIZE     = 128;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, cpu_err, err_flag;
    logic        dma_valid, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ready, dma_rvalid;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    int n_total = 0;
    int n_bad   = 0;

    dmem_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .MEM_SIZE    (MEM_SIZE),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_err    (cpu_err),
        .err_flag   (err_flag),
        .dma_valid  (dma_valid),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ready  (dma_ready),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT: async read, negedge write. Out-of-range
    // reads return a marker value so forced-zero paths are visible.
    logic [31:0] mem [0:MEM_SIZE-1];
    assign mem_rd_data = (mem_addr < MEM_SIZE) ? mem[mem_addr[6:0]] : 32'hBAD0_BAD0;
    always @(negedge clk) begin
        if (mem_wr_en && mem_addr < MEM_SIZE) mem[mem_addr[6:0]] <= mem_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: own copy of memory, own denied-streak count
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [0:MEM_SIZE-1];
    int          m_denied = 0;
    bit          m_err    = 0;
    logic [31:0] m_rdata  = 0;
    bit          m_rvalid = 0;
    bit          m_live   = 0;

    always begin : cmp
        longint unsigned widx;
        bit              bad_addr, g_dma, g_cpu, exp_we;
        logic [31:0]     exp_addr, exp_wdata, exp_crd;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            check("m_rst_wr_en", mem_wr_en, 0);
            check("m_rst_ready", dma_ready, 0);
            check("m_rst_stall", cpu_stall, 0);
            m_denied = 0; m_err = 0; m_rdata = 0; m_rvalid = 0; m_live = 1;
        end else if (m_live) begin
            widx     = longint'(cpu_addr) / 4;
            bad_addr = cpu_req && ((cpu_addr % 4) != 0 || widx >= MEM_SIZE);
            g_dma    = dma_valid && (!cpu_req || m_denied >= STARVE_LIMIT);
            g_cpu    = cpu_req && !g_dma;
            exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_crd = 0;
            if (g_cpu) begin
                exp_addr  = 32'(widx);
                exp_wdata = cpu_wdata;
                exp_we    = cpu_we && !bad_addr;
                if (!bad_addr) exp_crd = ref_mem[int'(widx)];
            end else if (g_dma) begin
                exp_addr  = dma_addr;
                exp_wdata = dma_wdata;
                exp_we    = dma_we && dma_addr < MEM_SIZE;
            end
            check("m_dma_ready", dma_ready, g_dma);
            check("m_cpu_stall", cpu_stall, cpu_req && !g_cpu);
            check("m_cpu_err", cpu_err, bad_addr);
            check("m_mem_addr", mem_addr, exp_addr);
            check("m_mem_wr_en", mem_wr_en, exp_we);
            if (exp_we) check("m_mem_wr_data", mem_wr_data, exp_wdata);
            if (!cpu_we) check("m_cpu_rdata", cpu_rdata, exp_crd);
            check("m_dma_rvalid", dma_rvalid, m_rvalid);
            check("m_dma_rdata", dma_rdata, m_rdata);
            check("m_err_flag", err_flag, m_err);
            // advance the model to the coming posedge
            if (g_dma && !dma_we) begin
                m_rdata  = (dma_addr < MEM_SIZE) ? ref_mem[int'(dma_addr)] : 32'h0;
                m_rvalid = 1;
            end else begin
                m_rvalid = 0;
            end
            if (exp_we) ref_mem[int'(exp_addr)] = exp_wdata;
            if (dma_valid && !g_dma) m_denied = (m_denied < STARVE_LIMIT) ? m_denied + 1 : STARVE_LIMIT;
            else m_denied = 0;
            if (g_cpu && bad_addr) m_err = 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: one call = one clock cycle; returns 7 time units after
    // the posedge so literal checks sample mid-cycle.
    // ------------------------------------------------------------------
    task automatic drive(input logic rn,
                         input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                         input logic dv, input logic dw, input logic [31:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        rst_n = rn;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd;
        dma_valid = dv; dma_we = dw; dma_addr = da; dma_wdata = dwd;
        #6;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]     = 32'hA500_0000 + 32'(i);
            ref_mem[i] = 32'hA500_0000 + 32'(i);
        end
        rst_n = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
        dma_valid = 1; dma_we = 1; dma_addr = 3; dma_wdata = 32'h2222_2222;

        // Reset held 2 cycles with both sides requesting writes
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 32'h10, 32'h1111_1111, 1, 1, 32'd3, 32'h2222_2222);
            check("rst_wr_en", mem_wr_en, 0);
            check("rst_dma_ready", dma_ready, 0);
            check("rst_cpu_stall", cpu_stall, 0);
            check("rst_dma_rvalid", dma_rvalid, 0);
            check("rst_err_flag", err_flag, 0);
        end
        idle();

        // CPU store then load
        drive(1, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
        check("st_mem_addr", mem_addr, 4);
        check("st_wr_en", mem_wr_en, 1);
        check("st_wr_data", mem_wr_data, 32'hDEAD_BEEF);
        drive(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        check("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("ld_stall", cpu_stall, 0);

        // DMA write then read of word 5
        drive(1, 0, 0, 0, 0, 1, 1, 32'd5, 32'h0000_1234);
        check("dwr_ready", dma_ready, 1);
        check("dwr_addr", mem_addr, 5);
        check("dwr_wr_en", mem_wr_en, 1);
        drive(1, 0, 0, 0, 0, 1, 0, 32'd5, 0);
        check("drd_ready", dma_ready, 1);
        idle();
        check("drd_rvalid", dma_rvalid, 1);
        check("drd_rdata", dma_rdata, 32'h0000_1234);
        idle();
        check("drd_rvalid_pulse", dma_rvalid, 0);

        // Starvation: DMA forced through every fifth cycle
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 0, 32'h10, 0, 1, 0, 32'd5, 0);
            check("starve_ready", dma_ready, (k % 5) == 4);
            check("starve_stall", cpu_stall, (k % 5) == 4);
            if (k == 0) check("starve_ld", cpu_rdata, 32'hDEAD_BEEF);
            if (k == 5) check("starve_rdata", dma_rdata, 32'h0000_1234);
        end
        idle();

        // DMA drops valid while waiting: the count starts over
        drive(1, 1, 0, 32'h10, 0, 1, 0, 32'd6, 0);
        drive(1, 1, 0, 32'h10, 0, 1, 0, 32'd6, 0);
        drive(1, 1, 0, 32'h10, 0, 0, 0, 32'd6, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 32'h10, 0, 1, 0, 32'd6, 0);
            check("drop_ready", dma_ready, k == 4);
        end
        idle();

        // Erroneous CPU accesses
        drive(1, 1, 1, 32'h202, 32'h5555_5555, 0, 0, 0, 0);
        check("mis_err", cpu_err, 1);
        check("mis_wr_en", mem_wr_en, 0);
        check("mis_stall", cpu_stall, 0);
        check("mis_flag_before", err_flag, 0);
        drive(1, 1, 1, 32'h200, 32'h6666_6666, 0, 0, 0, 0);
        check("oor_err", cpu_err, 1);
        check("oor_wr_en", mem_wr_en, 0);
        check("oor_flag", err_flag, 1);
        drive(1, 1, 1, 32'h12, 32'h7777_7777, 0, 0, 0, 0);
        check("mis_inrange_wr_en", mem_wr_en, 0);
        drive(1, 1, 0, 32'h11, 0, 0, 0, 0, 0);
        check("err_ld_rdata", cpu_rdata, 0);
        drive(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        check("err_ld_intact", cpu_rdata, 32'hDEAD_BEEF);
        check("err_ld_noerr", cpu_err, 0);
        check("flag_sticky", err_flag, 1);

        // DMA out-of-range read and write
        drive(1, 0, 0, 0, 0, 1, 0, 32'd200, 0);
        check("door_ready", dma_ready, 1);
        check("door_wr_en", mem_wr_en, 0);
        drive(1, 0, 0, 0, 0, 1, 1, 32'd200, 32'h9999_9999);
        check("door_rvalid", dma_rvalid, 1);
        check("door_rdata", dma_rdata, 0);
        check("doorw_wr_en", mem_wr_en, 0);

        // Back-to-back DMA writes then reads
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 32'(10 + i), 32'hC000_0000 + 32'(i));
            check("b2b_wr_ready", dma_ready, 1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 0, 0, 0, 0, 1, 0, 32'(10 + i), 0);
            else idle();
            if (i > 0) begin
                check("b2b_rvalid", dma_rvalid, 1);
                check("b2b_rdata", dma_rdata, 32'hC000_0000 + 32'(i - 1));
            end
        end

        // Reset in the middle of a wait, with writes pending
        drive(1, 1, 0, 32'h10, 0, 1, 0, 32'd7, 0);
        drive(1, 1, 0, 32'h10, 0, 1, 0, 32'd7, 0);
        drive(0, 1, 1, 32'h10, 32'hEEEE_EEEE, 1, 1, 32'd7, 32'hFFFF_FFFF);
        check("mid_rst_wr_en", mem_wr_en, 0);
        check("mid_rst_ready", dma_ready, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 32'h10, 0, 1, 0, 32'd7, 0);
            check("post_rst_ready", dma_ready, k == 4);
            if (k == 0) begin
                check("post_rst_flag", err_flag, 0);
                check("post_rst_ld", cpu_rdata, 32'hDEAD_BEEF);
            end
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a DMA/loader port used for program/data load and debug dump.
- CPU has default priority. A starvation counter forces a DMA grant after a bounded wait.
- Converts CPU byte addresses to word indices and checks range and alignment.
- Drives the memory's wr_en/addr/wr_data and returns read data to whichever requester owns the cycle.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, address width on all ports
- MEM_SIZE, 128, number of memory words; valid word indices are 0..MEM_SIZE-1
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA is forced through (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- cpu_req  in  1  MEM stage accesses memory this cycle (load or store)
- cpu_we  in  1  1 = store
- cpu_addr  in  ADDR_WIDTH  CPU byte address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdata  out  DATA_WIDTH  load data (combinational)
- cpu_stall  out  1  CPU access not granted; pipeline holds MEM stage
- cpu_err  out  1  current CPU access misaligned or out of range (combinational)
- err_flag  out  1  sticky: set by any granted erroneous CPU access
- dma_valid  in  1  DMA request pending
- dma_we  in  1  1 = DMA write
- dma_addr  in  ADDR_WIDTH  DMA word index
- dma_wdata  in  DATA_WIDTH  DMA write data
- dma_ready  out  1  DMA granted this cycle; transfer occurs when dma_valid & dma_ready
- dma_rdata  out  DATA_WIDTH  registered DMA read data
- dma_rvalid  out  1  one-cycle pulse: dma_rdata holds data of the previous DMA read
- mem_wr_en  out  1  to memory write enable (memory writes on negedge)
- mem_addr  out  ADDR_WIDTH  to memory word index
- mem_wr_data  out  DATA_WIDTH  to memory write data
- mem_rd_data  in  DATA_WIDTH  from memory, asynchronous read

Behaviour:
- Reset (rst_n=0 at posedge): wait_cnt=0, err_flag=0, dma_rdata=0, dma_rvalid=0.
  - Combinational outputs while rst_n=0: mem_wr_en=0, dma_ready=0, cpu_stall=0.
- Grant is decided combinationally each cycle:
  - force_dma = dma_valid & (wait_cnt == STARVE_LIMIT)
  - gnt_dma = dma_valid & (~cpu_req | force_dma)
  - gnt_cpu = cpu_req & ~gnt_dma
- Outputs from the grant:
  - dma_ready = gnt_dma
  - cpu_stall = cpu_req & ~gnt_cpu
- CPU address check:
  - word index = cpu_addr >> 2
  - cpu_err = cpu_req & (cpu_addr[1:0] != 0 | word index >= MEM_SIZE)
- Memory mux:
  - gnt_cpu: mem_addr = cpu word index; mem_wr_data = cpu_wdata; mem_wr_en = cpu_we & ~cpu_err.
  - gnt_dma: mem_addr = dma_addr; mem_wr_data = dma_wdata; mem_wr_en = dma_we & (dma_addr < MEM_SIZE).
  - Neither granted: mem_addr = 0, mem_wr_en = 0.
- Erroneous CPU store: write suppressed, no stall caused by the error. Erroneous CPU load: cpu_rdata forced to 0.
- cpu_rdata = mem_rd_data when gnt_cpu & ~cpu_err, else 0. Zero load latency, same cycle.
- DMA read:
  - At posedge, if gnt_dma & ~dma_we: dma_rdata <= mem_rd_data (0 if dma_addr out of range) and dma_rvalid <= 1.
  - Otherwise dma_rvalid <= 0 and dma_rdata holds.
  - Latency is 1 cycle after handshake.
- wait_cnt update at posedge:
  - dma_valid & ~gnt_dma: increment, saturating at STARVE_LIMIT.
  - gnt_dma or ~dma_valid: clear to 0.
- err_flag: set at posedge when gnt_cpu & cpu_err. Cleared only by reset.
- Simultaneous requests, normal case: CPU wins and DMA waits.
- Simultaneous requests, forced case: on the forced cycle DMA wins, the CPU stalls exactly 1 cycle, and wait_cnt returns to 0.
- Back-to-back DMA with no CPU traffic: a grant every cycle.
- DMA deasserting valid while waiting: counter clears; no partial state is kept.
- Reset mid-transfer: a pending DMA is dropped and the requester must re-issue. A write coinciding with a reset cycle is blocked (mem_wr_en=0).

Test Plan:
- Reset hold 2 cycles with cpu_req=dma_valid=1 -> mem_wr_en=0, dma_ready=0, dma_rvalid=0, err_flag=0; after release wait_cnt starts at 0.
- CPU store addr 0x10, data 0xDEADBEEF, then load 0x10 -> mem_addr=4, mem_wr_en=1 on the store; load cpu_rdata=0xDEADBEEF with cpu_stall=0.
- DMA write word 5 = 0x1234, then DMA read word 5 with no CPU -> dma_ready=1 on both; next cycle dma_rvalid=1, dma_rdata=0x1234.
- cpu_req=1 continuously and dma_valid=1 from cycle 0, STARVE_LIMIT=4 -> DMA denied cycles 0-3, granted cycle 4 with cpu_stall=1 that cycle only; pattern repeats every 5 cycles.
- CPU store to 0x202 (misaligned), then to 0x200 (word 128, out of range) -> cpu_err=1, mem_wr_en=0 both times; err_flag=1 from the next cycle and persists until reset.
- DMA read word 200 (out of range) -> handshake completes; dma_rvalid=1 with dma_rdata=0; no memory write.
